covariance_matrix_stream: RTL and testbench

COVARIANCE_MATRIX_STREAM -- requirements
Module: covariance_matrix_stream

---
 rtl/covariance_matrix_stream.sv | 185 ++++++++++++++++++
 tb/tb_covariance_matrix_stream.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/covariance_matrix_stream.sv
// covariance_matrix_stream
// Accumulates the upper-triangle outer products din[i]*din[j] (i<=j) of a
// stream of multi-channel signed samples over frames of acc_len samples, then
// serialises the frame totals row-major through a valid/ready readout port.
//
// Pipeline: sample accepted at edge E0 -> product registers (E0) ->
// accumulators (E1) -> readout bank load (E2) -> dout_valid from the next cycle.
//
// Ports
//   clk, rst_n      rising-edge clock, synchronous active-low reset
//   din             N_INPUTS signed channels, channel k at [k*DIN_WIDTH +: DIN_WIDTH]
//   din_valid       sample qualifier (no backpressure on the input side)
//   acc_len         frame length, latched on the first sample of a frame (0 acts as 1)
//   dout            covariance term, dout_index its row-major triangle index
//   dout_valid/dout_ready/dout_last  readout handshake, last marks the final term
//   overflow        sticky: a frame closed while the readout was still busy
//   saturated       sticky: an accumulator clipped
//   dbg_state       readout FSM state (0 = IDLE, 1 = SEND)
//
// Handshake: a word transfers on a cycle where dout_valid && dout_ready; while
// dout_valid && !dout_ready, dout/dout_index/dout_last hold their values and
// dout_valid stays high until the transfer happens.
module covariance_matrix_stream #(
  parameter int DIN_WIDTH = 8,
  parameter int N_INPUTS  = 4,
  parameter int ACC_WIDTH = 32,
  parameter int LEN_WIDTH = 16,
  localparam int N_OUTPUTS = N_INPUTS * (N_INPUTS + 1) / 2,
  localparam int IDX_WIDTH = (N_OUTPUTS > 1) ? $clog2(N_OUTPUTS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_INPUTS*DIN_WIDTH-1:0] din,
  input  logic                          din_valid,
  input  logic [LEN_WIDTH-1:0]          acc_len,
  output logic [ACC_WIDTH-1:0]          dout,
  output logic [IDX_WIDTH-1:0]          dout_index,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic                          dout_last,
  output logic                          overflow,
  output logic                          saturated,
  output logic                          dbg_state
);

  localparam int PW = 2 * DIN_WIDTH;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  // Channel unpacking
  logic signed [DIN_WIDTH-1:0] ch [N_INPUTS];
  for (genvar g = 0; g < N_INPUTS; g++) begin : g_ch
    assign ch[g] = din[g*DIN_WIDTH +: DIN_WIDTH];
  end

  // Frame counting
  logic [LEN_WIDTH-1:0] cnt_q, len_q, eff_len_d;
  logic                 frame_end_d;

  // A new frame starts whenever the counter is at zero; its length comes
  // straight from the port, later samples use the latched copy.
  always_comb begin
    eff_len_d = len_q;
    if (cnt_q == '0) eff_len_d = (acc_len == '0) ? LEN_WIDTH'(1) : acc_len;
    frame_end_d = ((cnt_q + LEN_WIDTH'(1)) == eff_len_d);
  end

  // Product stage
  logic signed [PW-1:0] prod_d [N_OUTPUTS];
  logic signed [PW-1:0] prod_q [N_OUTPUTS];
  logic                 prod_valid_q, prod_first_q, prod_last_q;

  always_comb begin
    int k;
    k = 0;
    for (int n = 0; n < N_OUTPUTS; n++) prod_d[n] = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      for (int j = i; j < N_INPUTS; j++) begin
        prod_d[k] = PW'(ch[i]) * PW'(ch[j]);
        k++;
      end
    end
  end

  // Accumulator stage with signed saturation
  logic [ACC_WIDTH-1:0] acc_d [N_OUTPUTS];
  logic [ACC_WIDTH-1:0] acc_q [N_OUTPUTS];
  logic                 acc_last_q;
  logic                 sat_d;

  always_comb begin
    sat_d = 1'b0;
    for (int k = 0; k < N_OUTPUTS; k++) begin : g_acc
      logic [ACC_WIDTH-1:0] base;
      logic [ACC_WIDTH:0]   sum;
      // The first product of a frame replaces the old total.
      base = prod_first_q ? '0 : acc_q[k];
      sum  = {base[ACC_WIDTH-1], base}
           + {{(ACC_WIDTH + 1 - PW){prod_q[k][PW-1]}}, prod_q[k]};
      acc_d[k] = sum[ACC_WIDTH-1:0];
      // Disagreeing top two bits means the true sum left the ACC_WIDTH range.
      if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
        sat_d    = 1'b1;
        acc_d[k] = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                  : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end
    end
  end

  // Readout
  state_t               state_q;
  logic [ACC_WIDTH-1:0] bank_q [N_OUTPUTS];
  logic [IDX_WIDTH-1:0] idx_q;
  logic                 overflow_q, saturated_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      len_q        <= '0;
      prod_valid_q <= 1'b0;
      prod_first_q <= 1'b0;
      prod_last_q  <= 1'b0;
      acc_last_q   <= 1'b0;
      state_q      <= IDLE;
      idx_q        <= '0;
      overflow_q   <= 1'b0;
      saturated_q  <= 1'b0;
      for (int k = 0; k < N_OUTPUTS; k++) begin
        prod_q[k] <= '0;
        acc_q[k]  <= '0;
        bank_q[k] <= '0;
      end
    end else begin
      // Sample acceptance and product registers
      prod_valid_q <= din_valid;
      prod_first_q <= din_valid && (cnt_q == '0);
      prod_last_q  <= din_valid && frame_end_d;
      if (din_valid) begin
        if (cnt_q == '0) len_q <= eff_len_d;
        cnt_q <= frame_end_d ? '0 : cnt_q + LEN_WIDTH'(1);
        for (int k = 0; k < N_OUTPUTS; k++) prod_q[k] <= prod_d[k];
      end

      // Accumulation
      acc_last_q <= prod_valid_q && prod_last_q;
      if (prod_valid_q) begin
        for (int k = 0; k < N_OUTPUTS; k++) acc_q[k] <= acc_d[k];
        if (sat_d) saturated_q <= 1'b1;
      end

      // Readout FSM
      case (state_q)
        IDLE: begin
          if (acc_last_q) begin
            for (int k = 0; k < N_OUTPUTS; k++) bank_q[k] <= acc_q[k];
            idx_q   <= '0;
            state_q <= SEND;
          end
        end
        SEND: begin
          // A frame closing now is lost, even on the final-transfer cycle.
          if (acc_last_q) overflow_q <= 1'b1;
          if (dout_ready) begin
            if (idx_q == IDX_WIDTH'(N_OUTPUTS - 1)) begin
              idx_q   <= '0;
              state_q <= IDLE;
            end else begin
              idx_q <= idx_q + IDX_WIDTH'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dout       = bank_q[idx_q];
  assign dout_index = idx_q;
  assign dout_valid = (state_q == SEND);
  assign dout_last  = (state_q == SEND) && (idx_q == IDX_WIDTH'(N_OUTPUTS - 1));
  assign overflow   = overflow_q;
  assign saturated  = saturated_q;
  assign dbg_state  = (state_q == SEND);

endmodule

// File: tb/tb_covariance_matrix_stream.sv
// Bench for covariance_matrix_stream with N_INPUTS=2 (three terms).
// Instance a uses ACC_WIDTH=32, instance b ACC_WIDTH=16 (saturation case);
// both see the same stimulus.
module tb_covariance_matrix_stream;

  localparam int EW = 1 + 2 + 32;  // {last, index, dout}

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] din = '0;
  logic        din_valid = 1'b0;
  logic [15:0] acc_len = '0;
  logic        dout_ready = 1'b0;

  logic [31:0] dout_a;
  logic [1:0]  idx_a;
  logic        valid_a, last_a, ovf_a, sat_a, st_a;
  logic [15:0] dout_b;
  logic [1:0]  idx_b;
  logic        valid_b, last_b, ovf_b, sat_b, st_b;

  int tests_run = 0;
  int tests_failed = 0;
  logic [EW-1:0] exp_q[$];

  logic toggle_en = 1'b0;
  logic ready_level = 1'b1;

  covariance_matrix_stream #(.DIN_WIDTH(8), .N_INPUTS(2), .ACC_WIDTH(32), .LEN_WIDTH(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .acc_len(acc_len),
    .dout(dout_a), .dout_index(idx_a), .dout_valid(valid_a), .dout_ready(dout_ready),
    .dout_last(last_a), .overflow(ovf_a), .saturated(sat_a), .dbg_state(st_a));

  covariance_matrix_stream #(.DIN_WIDTH(8), .N_INPUTS(2), .ACC_WIDTH(16), .LEN_WIDTH(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .acc_len(acc_len),
    .dout(dout_b), .dout_index(idx_b), .dout_valid(valid_b), .dout_ready(dout_ready),
    .dout_last(last_b), .overflow(ovf_b), .saturated(sat_b), .dbg_state(st_b));

  // Clock
  always #5 clk = ~clk;

  // Ready driver: fixed level or toggling every cycle
  initial begin
    forever begin
      @(posedge clk);
      #1;
      dout_ready = toggle_en ? ~dout_ready : ready_level;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard for instance a: every transfer pops one expected word, and a
  // stalled word must be unchanged on the next cycle.
  logic          hold_pend = 1'b0;
  logic [EW:0]   held = '0;
  logic [EW-1:0] e;
  always @(negedge clk) begin
    if (hold_pend) check("hold_stable", {valid_a, last_a, idx_a, dout_a}, held);
    if (valid_a && dout_ready) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_word: got idx %0d data %0h expected none", idx_a, dout_a);
      end else begin
        e = exp_q.pop_front();
        check("word", {last_a, idx_a, dout_a}, e);
      end
    end
    hold_pend = rst_n && valid_a && !dout_ready;
    held = {1'b1, last_a, idx_a, dout_a};
  end

  task automatic push3(input logic signed [31:0] a, input logic signed [31:0] b,
                       input logic signed [31:0] c);
    exp_q.push_back({1'b0, 2'd0, a});
    exp_q.push_back({1'b0, 2'd1, b});
    exp_q.push_back({1'b1, 2'd2, c});
  endtask

  // One valid sample; returns #1 after the accepting edge with junk on the
  // idle inputs.
  task automatic send(input logic signed [7:0] c0, input logic signed [7:0] c1,
                      input logic [15:0] len);
    din = {c1, c0};
    acc_len = len;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    din = 16'($urandom);
    acc_len = 16'($urandom);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && !valid_a) break;
      @(posedge clk);
      #1;
    end
    check("drain_pending_words", 64'(exp_q.size()), 64'd0);
    check("drain_valid_low", 64'(valid_a), 64'd0);
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dout"}, 64'(dout_a), 64'd0);
    check({tag, "_index"}, 64'(idx_a), 64'd0);
    check({tag, "_valid"}, 64'(valid_a), 64'd0);
    check({tag, "_last"}, 64'(last_a), 64'd0);
    check({tag, "_overflow"}, 64'(ovf_a), 64'd0);
    check({tag, "_saturated"}, 64'(sat_a), 64'd0);
  endtask

  typedef struct {
    logic [15:0]        len;
    logic signed [7:0]  c0;
    logic signed [7:0]  c1;
    int                 n;
    logic signed [31:0] e0;
    logic signed [31:0] e1;
    logic signed [31:0] e2;
  } vec_t;
  vec_t tbl[6];

  initial begin
    tbl[0] = '{16'd4, 8'sd1,    -8'sd2,   4, 32'sd4,     -32'sd8,     32'sd16};
    tbl[1] = '{16'd1, 8'sd3,    8'sd5,    1, 32'sd9,     32'sd15,     32'sd25};
    tbl[2] = '{16'd0, -8'sd4,   8'sd7,    1, 32'sd16,    -32'sd28,    32'sd49};
    tbl[3] = '{16'd3, -8'sd128, 8'sd127,  3, 32'sd49152, -32'sd48768, 32'sd48387};
    tbl[4] = '{16'd2, 8'sd0,    -8'sd1,   2, 32'sd0,     32'sd0,      32'sd2};
    tbl[5] = '{16'd5, 8'sd10,   -8'sd10,  5, 32'sd500,   -32'sd500,   32'sd500};

    // Reset state
    rst_n = 1'b0;
    cycles(2);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    cycles(1);

    // Basic frame with first-valid latency
    push3(32'sd4, -32'sd8, 32'sd16);
    for (int i = 0; i < 4; i++) send(8'sd1, -8'sd2, 16'd4);
    check("latency_t1_valid", 64'(valid_a), 64'd0);
    cycles(1);
    check("latency_t2_valid", 64'(valid_a), 64'd0);
    cycles(1);
    check("latency_t3_valid", 64'(valid_a), 64'd1);
    check("latency_t3_index", 64'(idx_a), 64'd0);
    wait_drain(20);

    // Vector table
    for (int v = 0; v < 6; v++) begin
      push3(tbl[v].e0, tbl[v].e1, tbl[v].e2);
      for (int s = 0; s < tbl[v].n; s++) send(tbl[v].c0, tbl[v].c1, tbl[v].len);
      wait_drain(30);
    end
    check("table_overflow", 64'(ovf_a), 64'd0);
    check("table_saturated", 64'(sat_a), 64'd0);

    // Backpressure: ready toggles every cycle
    toggle_en = 1'b1;
    push3(32'sd4, -32'sd8, 32'sd16);
    for (int i = 0; i < 4; i++) send(8'sd1, -8'sd2, 16'd4);
    wait_drain(40);
    toggle_en = 1'b0;
    cycles(2);

    // Length change mid-frame: first frame still uses 4
    push3(32'sd4, 32'sd4, 32'sd4);
    send(8'sd1, 8'sd1, 16'd4);
    for (int i = 0; i < 3; i++) send(8'sd1, 8'sd1, 16'd2);
    wait_drain(30);
    push3(32'sd8, 32'sd4, 32'sd2);
    for (int i = 0; i < 2; i++) send(8'sd2, 8'sd1, 16'd2);
    wait_drain(30);

    // Overflow: second frame closes while the first is still being read
    ready_level = 1'b0;
    cycles(2);
    send(8'sd1, 8'sd1, 16'd1);
    send(8'sd3, 8'sd3, 16'd1);
    cycles(3);
    check("ovf_flag", 64'(ovf_a), 64'd1);
    check("ovf_valid_stalled", 64'(valid_a), 64'd1);
    check("ovf_held_dout", 64'(dout_a), 64'd1);
    push3(32'sd1, 32'sd1, 32'sd1);
    ready_level = 1'b1;
    wait_drain(30);
    cycles(5);
    check("ovf_no_second_readout", 64'(valid_a), 64'd0);
    check("ovf_sticky", 64'(ovf_a), 64'd1);

    // Reset mid-frame, then a clean frame
    send(8'sd1, -8'sd2, 16'd4);
    send(8'sd1, -8'sd2, 16'd4);
    rst_n = 1'b0;
    cycles(1);
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    cycles(1);
    push3(32'sd4, -32'sd8, 32'sd16);
    for (int i = 0; i < 4; i++) send(8'sd1, -8'sd2, 16'd4);
    wait_drain(20);

    // Saturation on the 16-bit instance
    check("sat_b_before", 64'(sat_b), 64'd0);
    push3(32'sd32768, 32'sd32768, 32'sd32768);
    send(-8'sd128, -8'sd128, 16'd2);
    send(-8'sd128, -8'sd128, 16'd2);
    cycles(2);
    for (int k = 0; k < 3; k++) begin
      check("sat_b_valid", 64'(valid_b), 64'd1);
      check("sat_b_dout", 64'(dout_b), 64'h7fff);
      check("sat_b_index", 64'(idx_b), 64'(k));
      check("sat_b_last", 64'(last_b), (k == 2) ? 64'd1 : 64'd0);
      cycles(1);
    end
    check("sat_b_flag", 64'(sat_b), 64'd1);
    check("sat_a_flag", 64'(sat_a), 64'd0);
    wait_drain(20);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global time guard
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
